fake_netlist_vec_driver: RTL and testbench

//  Drives the other end of a 5-input / 1-output fake netlist such as fake_jpeg_*_n_11.

---
 rtl/fake_netlist_vec_driver.sv | 126 ++++++++++++
 tb/tb_fake_netlist_vec_driver.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fake_netlist_vec_driver.sv
// fake_netlist_vec_driver
//   Stimulus/response harness for a small combinational "fake netlist" with
//   IN_W inputs (n_0..n_{IN_W-1}) and one output (n_11). A maximal-length LFSR
//   produces the input vectors. Each vector is held for CAP_DLY+1 cycles. On
//   the last cycle of each vector, the returned bit is folded into a MISR
//   signature. A start/busy/done handshake frames each run of NUM_VEC vectors.
//
// Ports
//   clk        in   1      clock
//   rst_n      in   1      synchronous active-low reset
//   start_i    in   1      run request, honoured only while idle
//   vec_o      out  IN_W   stimulus vector; bit i drives netlist input n_i
//   resp_i     in   1      netlist output (n_11)
//   busy_o     out  1      run in progress
//   done_o     out  1      one-cycle pulse after the final capture
//   sig_o      out  SIG_W  MISR signature, held after a run until next start
//   vec_cnt_o  out  8      vectors captured so far (saturates at 255)
module fake_netlist_vec_driver #(
  parameter int                IN_W    = 5,
  parameter logic [IN_W-1:0]   SEED    = 5'h01,
  parameter int                NUM_VEC = 32,
  parameter int                CAP_DLY = 1,
  parameter int                SIG_W   = 16,
  parameter logic [SIG_W-1:0]  POLY    = 16'h1021
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  output logic [IN_W-1:0]  vec_o,
  input  logic             resp_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [SIG_W-1:0] sig_o,
  output logic [7:0]       vec_cnt_o
);

  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [IN_W-1:0] SEED_EFF =
    (SEED == '0) ? {{(IN_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [3:0]  CAP_LAST = 4'(CAP_DLY);
  localparam logic [31:0] LAST_IDX = 32'(NUM_VEC - 1);

  typedef enum logic [1:0] {S_IDLE, S_APPLY, S_DONE} state_t;

  // x^5 + x^3 + 1 Fibonacci LFSR, period 31.
  function automatic logic [IN_W-1:0] lfsr_step(input logic [IN_W-1:0] v);
    return {v[IN_W-2:0], v[IN_W-1] ^ v[IN_W-3]};
  endfunction

  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                 input logic             r);
    logic [SIG_W-1:0] nxt;
    nxt = {s[SIG_W-2:0], 1'b0};
    if (s[SIG_W-1]) nxt = nxt ^ POLY;
    nxt[0] = nxt[0] ^ r;
    return nxt;
  endfunction

  state_t           state_q;
  logic [IN_W-1:0]  vec_q, lfsr_q, lfsr_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [31:0]      cnt_q;  // wide so NUM_VEC > 255 still terminates correctly
  logic [3:0]       wait_q;
  logic             busy_q, done_q;

  assign lfsr_d = lfsr_step(lfsr_q);
  assign sig_d  = misr_step(sig_q, resp_i);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      lfsr_q  <= SEED_EFF;
      sig_q   <= '0;
      cnt_q   <= '0;
      wait_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            state_q <= S_APPLY;
            vec_q   <= SEED_EFF;
            lfsr_q  <= SEED_EFF;
            sig_q   <= '0;
            cnt_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_APPLY: begin
          if (wait_q < CAP_LAST) begin
            wait_q <= wait_q + 4'd1;
          end else begin
            // Capture edge: the response to the current vector is folded in.
            wait_q <= '0;
            sig_q  <= sig_d;
            cnt_q  <= cnt_q + 32'd1;
            if (cnt_q == LAST_IDX) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              vec_q  <= lfsr_d;
              lfsr_q <= lfsr_d;
            end
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign vec_o     = vec_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign sig_o     = sig_q;
  assign vec_cnt_o = (cnt_q > 32'd255) ? 8'hFF : cnt_q[7:0];

endmodule

// File: tb/tb_fake_netlist_vec_driver.sv
// Testbench for fake_netlist_vec_driver. Three instances with different
// parameters are driven; expectations are queued as runs are launched and a
// negedge monitor checks every busy cycle and every done pulse against them.
module tb_fake_netlist_vec_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start [3];
  logic [4:0]  vec   [3];
  logic        resp  [3];
  logic        busy  [3];
  logic        done  [3];
  logic [15:0] sig   [3];
  logic [7:0]  cnt   [3];
  int          mode  [3];   // 0: resp=0, 1: resp=1, 2: stand-in netlist

  int n_tests = 0;
  int n_fail  = 0;

  // Instance parameters, mirrored for the expectation model.
  int nv [3] = '{32, 3, 300};
  int cd [3] = '{1, 0, 2};
  logic [4:0] sd [3] = '{5'h01, 5'h01, 5'h1B};

  typedef struct packed {
    logic [15:0] sig;
    logic [7:0]  cnt;
    logic [4:0]  vec;
  } done_t;

  logic [4:0] exp_vec  [3][$];
  done_t      exp_done [3][$];

  always #5 clk = ~clk;

  fake_netlist_vec_driver u_a (
    .clk(clk), .rst_n(rst_n), .start_i(start[0]), .vec_o(vec[0]),
    .resp_i(resp[0]), .busy_o(busy[0]), .done_o(done[0]), .sig_o(sig[0]),
    .vec_cnt_o(cnt[0]));

  fake_netlist_vec_driver #(.NUM_VEC(3), .CAP_DLY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .start_i(start[1]), .vec_o(vec[1]),
    .resp_i(resp[1]), .busy_o(busy[1]), .done_o(done[1]), .sig_o(sig[1]),
    .vec_cnt_o(cnt[1]));

  fake_netlist_vec_driver #(.SEED(5'h1B), .NUM_VEC(300), .CAP_DLY(2)) u_c (
    .clk(clk), .rst_n(rst_n), .start_i(start[2]), .vec_o(vec[2]),
    .resp_i(resp[2]), .busy_o(busy[2]), .done_o(done[2]), .sig_o(sig[2]),
    .vec_cnt_o(cnt[2]));

  // Stand-in for the fake netlist n_11 cone.
  function automatic logic netlist(input logic [4:0] v);
    return (v[0] & v[1]) ^ (v[2] | v[4]) ^ v[3];
  endfunction

  function automatic logic resp_model(input int m, input logic [4:0] v);
    if (m == 0) return 1'b0;
    if (m == 1) return 1'b1;
    return netlist(v);
  endfunction

  always_comb begin
    for (int i = 0; i < 3; i++) resp[i] = resp_model(mode[i], vec[i]);
  end

  function automatic logic [4:0] m_lfsr(input logic [4:0] v);
    return {v[3:0], v[4] ^ v[2]};
  endfunction

  function automatic logic [15:0] m_misr(input logic [15:0] s, input logic r);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {15'd0, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_run(input int i);
    logic [4:0]  l;
    logic [15:0] s;
    done_t       d;
    l = (sd[i] == 5'd0) ? 5'd1 : sd[i];
    s = '0;
    for (int k = 0; k < nv[i]; k++) begin
      for (int j = 0; j <= cd[i]; j++) exp_vec[i].push_back(l);
      s = m_misr(s, resp_model(mode[i], l));
      if (k < nv[i] - 1) l = m_lfsr(l);
    end
    d.sig = s;
    d.cnt = (nv[i] > 255) ? 8'hFF : 8'(nv[i]);
    d.vec = l;
    exp_done[i].push_back(d);
  endtask

  task automatic start_run(input int i);
    push_run(i);
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int lim);
    bit seen = 0;
    for (int c = 0; c < lim && !seen; c++) begin
      @(posedge clk); #1;
      if (done[i] === 1'b1) seen = 1;
    end
    if (!seen) chk($sformatf("done_timeout[%0d]", i), 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (busy[i] === 1'b1) begin
        if (exp_vec[i].size() == 0) begin
          chk($sformatf("busy_extra[%0d]", i), 32'd1, 32'd0);
        end else begin
          logic [4:0] e;
          e = exp_vec[i].pop_front();
          chk($sformatf("vec[%0d]", i), 32'(vec[i]), 32'(e));
        end
      end
      if (done[i] === 1'b1) begin
        if (exp_done[i].size() == 0) begin
          chk($sformatf("done_unexpected[%0d]", i), 32'd1, 32'd0);
        end else begin
          done_t d;
          d = exp_done[i].pop_front();
          chk($sformatf("sig[%0d]", i), 32'(sig[i]), 32'(d.sig));
          chk($sformatf("cnt[%0d]", i), 32'(cnt[i]), 32'(d.cnt));
          chk($sformatf("last_vec[%0d]", i), 32'(vec[i]), 32'(d.vec));
          chk($sformatf("busy_short[%0d]", i), 32'(exp_vec[i].size()), 32'd0);
          chk($sformatf("busy_at_done[%0d]", i), 32'(busy[i]), 32'd0);
        end
      end
    end
  end

  logic [4:0]  hand_vec [5] = '{5'h01, 5'h02, 5'h04, 5'h09, 5'h12};
  logic [15:0] hist [8];
  int          bc;
  bit          seen_d, pushed2;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    mode[0] = 0; mode[1] = 1; mode[2] = 2;

    // T1: reset
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_vec[%0d]", i),  32'(vec[i]),  32'd0);
      chk($sformatf("rst_busy[%0d]", i), 32'(busy[i]), 32'd0);
      chk($sformatf("rst_done[%0d]", i), 32'(done[i]), 32'd0);
      chk($sformatf("rst_sig[%0d]", i),  32'(sig[i]),  32'd0);
      chk($sformatf("rst_cnt[%0d]", i),  32'(cnt[i]),  32'd0);
    end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_busy", 32'(busy[0]), 32'd0);
    chk("idle_vec",  32'(vec[0]),  32'd0);

    // T2/T4: defaults, resp=0, hand-checked vector sequence and wrap
    start_run(0);
    for (int k = 0; k < 32; k++) begin
      if (k < 5) chk($sformatf("t2_vec%0d", k), 32'(vec[0]), 32'(hand_vec[k]));
      if (k == 31) chk("t4_wrap_vec32", 32'(vec[0]), 32'h01);
      repeat (2) @(posedge clk);
      #1;
    end
    chk("t2_done_cycle65", 32'(done[0]), 32'd1);
    chk("t2_sig", 32'(sig[0]), 32'h0000);
    chk("t2_cnt", 32'(cnt[0]), 32'd32);
    @(posedge clk); #1;
    chk("t2_done_pulse_len", 32'(done[0]), 32'd0);

    // T3: 3 vectors, no hold, resp=1
    start_run(1);
    bc = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy[1] === 1'b1) begin
        hist[bc[2:0]] = sig[1];
        bc++;
      end
      if (done[1] === 1'b1) break;
      @(posedge clk); #1;
    end
    chk("t3_busy_cycles", 32'(bc), 32'd3);
    chk("t3_sig_step1", 32'(hist[1]), 32'h0001);
    chk("t3_sig_step2", 32'(hist[2]), 32'h0003);
    chk("t3_sig_final", 32'(sig[1]), 32'h0007);
    @(posedge clk); #1;

    // T6 + T5 start pulse mid-run: closed loop on A
    mode[0] = 2;
    start_run(0);
    repeat (10) @(posedge clk);
    #1;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    wait_done(0, 200);

    // Closed loop, SEED=1B, 300 vectors: LFSR wrap and count saturation
    start_run(2);
    wait_done(2, 1200);
    chk("c_cnt_sat", 32'(cnt[2]), 32'd255);

    // start_i held high: second run right after DONE
    push_run(1);
    start[1] = 1'b1;
    seen_d = 0; pushed2 = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (seen_d && !pushed2) begin
        push_run(1);
        pushed2 = 1;
      end
      if (done[1] === 1'b1) seen_d = 1;
      if (pushed2 && busy[1] === 1'b1) break;
    end
    start[1] = 1'b0;
    chk("held_restart", 32'(busy[1]), 32'd1);
    wait_done(1, 30);

    // T5: reset at vector 10 aborts the run
    start_run(0);
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    exp_vec[0].delete();
    exp_done[0].delete();
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_sig",  32'(sig[0]),  32'd0);
    chk("abort_cnt",  32'(cnt[0]),  32'd0);
    chk("abort_vec",  32'(vec[0]),  32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done[0]), 32'd0);

    // Restart after abort begins again from the seed
    start_run(0);
    wait_done(0, 200);

    for (int i = 0; i < 3; i++)
      chk($sformatf("sb_drained[%0d]", i),
          32'(exp_vec[i].size() + exp_done[i].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
